mem_arbiter: RTL and testbench

- Shares the core's single external memory bus master port between two requesters: the fetch unit (instruction port, read-only) and the LSU (data port, read/write).
- Data requests take priority, which keeps LSU stalls (busy_M into the hazard controller) short. A starvation counter guarantees forward progress for fetch.
- A per-transaction watchdog terminates hung bus cycles with an error response.
- Sits between the core (IFU/LSU) and the bus interconnect.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester bus arbiter: LSU data requests win over fetch, a starvation counter
// bounds how long fetch can lose, and a watchdog terminates hung bus cycles with an error.
//   state | meaning
//   IDLE  | no bus cycle; arbitrates unless an ack is being returned this cycle
//   GNT_I | fetch owns the bus until m_ack or watchdog expiry
//   GNT_D | data owns the bus until m_ack or watchdog expiry
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_sel,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_cyc,
  output logic              m_we,
  output logic [XLEN/8-1:0] m_sel,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  input  logic [XLEN-1:0]   m_rdata,
  input  logic              m_ack
);

  localparam int SEL_W = XLEN / 8;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              m_cyc_q, m_cyc_d, m_we_q, m_we_d;
  logic [SEL_W-1:0]  m_sel_q, m_sel_d;
  logic [XLEN-1:0]   m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic              wd_hit;

  // The watchdog fires on the TIMEOUT-th cycle of the bus cycle, so m_cyc is high TIMEOUT cycles.
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    i_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    m_cyc_d      = m_cyc_q;
    m_we_d       = m_we_q;
    m_sel_d      = m_sel_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        // The requester still holds req during its ack cycle, so no arbitration then.
        if (!(i_ack_q || d_ack_q)) begin
          if (d_req && !(i_req && starve_cnt_q == SC_MAX)) begin
            state_d   = GNT_D;
            m_cyc_d   = 1'b1;
            m_we_d    = d_we;
            m_sel_d   = d_sel;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            wd_cnt_d  = '0;
            if (i_req && starve_cnt_q != SC_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
          end else if (i_req) begin
            state_d      = GNT_I;
            m_cyc_d      = 1'b1;
            m_we_d       = 1'b0;
            m_sel_d      = '1;
            m_addr_d     = i_addr;
            wd_cnt_d     = '0;
            starve_cnt_d = '0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (m_ack || wd_hit) begin
          state_d = IDLE;
          m_cyc_d = 1'b0;
          if (state_q == GNT_I) begin
            i_ack_d   = 1'b1;
            i_err_d   = !m_ack;
            i_rdata_d = m_ack ? m_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = !m_ack;
            d_rdata_d = (m_ack && !m_we_q) ? m_rdata : '0;
          end
        end else if (TIMEOUT != 0) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      m_cyc_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_sel_q      <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      m_cyc_q      <= m_cyc_d;
      m_we_q       <= m_we_d;
      m_sel_q      <= m_sel_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;
  assign m_cyc   = m_cyc_q;
  assign m_we    = m_we_q;
  assign m_sel   = m_sel_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus cycles and responses are queued when a
// request is driven and checked by a monitor when the DUT produces them.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0]  d_sel = '0;
  logic        i_ack, i_err, d_ack, d_err, m_cyc, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_sel;

  typedef struct packed {logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata; int len;} bus_t;
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;

  bus_t bus_exp[$];
  rsp_t i_exp[$], d_exp[$];
  int   checks = 0, errors = 0;

  int          rsp_wait = 0;
  logic [31:0] rsp_rdata = '0;
  logic        junk_ack = 1'b0;
  int          age = 0;

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  // Bus slave: acks on cycle rsp_wait+1 of each bus cycle; rsp_wait < 0 never acks.
  always @(negedge clk) begin
    if (m_cyc && rst_n) begin
      age = age + 1;
      m_ack = (rsp_wait >= 0) && (age == rsp_wait + 1);
    end else begin
      age = 0;
      m_ack = junk_ack;
    end
    m_rdata = m_ack ? rsp_rdata : 32'hFFFF_FFFF;
  end

  // Monitor: checks every bus cycle and every response against the queues.
  logic prev_cyc = 1'b0, prev_iack = 1'b0, prev_dack = 1'b0;
  int   cyc_len = 0;
  bus_t cur = '0;
  logic [68:0] held = '0;
  rsp_t r;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0; cyc_len = 0;
    end else begin
      if (m_cyc && !prev_cyc) begin
        checks++;
        cyc_len = 1;
        held = {m_we, m_sel, m_addr, m_wdata};
        if (bus_exp.size() == 0) begin
          errors++; cur = '0;
          $display("FAIL bus_unexpected: got addr=%h we=%b, no cycle expected", m_addr, m_we);
        end else begin
          cur = bus_exp.pop_front();
          if ({m_we, m_sel, m_addr} !== {cur.we, cur.sel, cur.addr} || (cur.we && m_wdata !== cur.wdata)) begin
            errors++;
            $display("FAIL bus_grant: got we=%b sel=%h addr=%h wdata=%h, need we=%b sel=%h addr=%h wdata=%h",
                     m_we, m_sel, m_addr, m_wdata, cur.we, cur.sel, cur.addr, cur.wdata);
          end
        end
      end else if (m_cyc) begin
        cyc_len++;
        checks++;
        if ({m_we, m_sel, m_addr, m_wdata} !== held) begin
          errors++;
          $display("FAIL bus_hold: got %h, need %h", {m_we, m_sel, m_addr, m_wdata}, held);
        end
      end else if (prev_cyc && cur.len != 0) begin
        checks++;
        if (cyc_len != cur.len) begin
          errors++;
          $display("FAIL bus_len: m_cyc high %0d cycles, need %0d", cyc_len, cur.len);
        end
      end
      if (i_ack) begin
        checks++;
        if (prev_iack) begin errors++; $display("FAIL i_ack_pulse: got 2-cycle ack, need 1"); end
        else if (i_exp.size() == 0) begin errors++; $display("FAIL i_ack_unexpected: got ack, need none"); end
        else begin
          r = i_exp.pop_front();
          if ({i_err, i_rdata} !== r) begin
            errors++;
            $display("FAIL i_rsp: got err=%b rdata=%h, need err=%b rdata=%h", i_err, i_rdata, r.err, r.rdata);
          end
        end
      end
      if (d_ack) begin
        checks++;
        if (prev_dack) begin errors++; $display("FAIL d_ack_pulse: got 2-cycle ack, need 1"); end
        else if (d_exp.size() == 0) begin errors++; $display("FAIL d_ack_unexpected: got ack, need none"); end
        else begin
          r = d_exp.pop_front();
          if ({d_err, d_rdata} !== r) begin
            errors++;
            $display("FAIL d_rsp: got err=%b rdata=%h, need err=%b rdata=%h", d_err, d_rdata, r.err, r.rdata);
          end
        end
      end
      prev_cyc = m_cyc; prev_iack = i_ack; prev_dack = d_ack;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, m_cyc, m_we, m_sel, m_addr, m_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs m_cyc=%b m_addr=%h, need all 0", m_cyc, m_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int n;
    junk_ack = 1'b1;
    repeat (3) @(negedge clk);
    junk_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (m_cyc !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: got m_cyc=%b i_ack=%b d_ack=%b, need 0", m_cyc, i_ack, d_ack);
    end
    rsp_wait = 0; rsp_rdata = 32'h0000_0013;
    bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0, len: 1});
    i_exp.push_back('{err: 1'b0, rdata: 32'h0000_0013});
    i_addr = 32'h100; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 20);
    i_req = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL fetch_latency: got ack after %0d cycles, need 2", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_data_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int wait_cyc, input logic [31:0] bus_rdata);
    int n;
    rsp_wait = wait_cyc; rsp_rdata = bus_rdata;
    bus_exp.push_back('{we: we, sel: sel, addr: addr, wdata: wdata, len: wait_cyc + 1});
    d_exp.push_back('{err: 1'b0, rdata: we ? 32'h0 : bus_rdata});
    d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 30);
    d_req = 1'b0;
    checks++;
    if (!d_ack) begin errors++; $display("FAIL data_ack_timeout: got no d_ack in %0d cycles, need ack", n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    int acks;
    logic is_d;
    rst_n = 1'b0;
    @(negedge clk);
    rsp_wait = 0; rsp_rdata = 32'h0000_55AA;
    i_addr = 32'h400; d_addr = 32'h3000; d_we = 1'b0; d_sel = 4'hF; d_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      is_d = (k % 5) != 4;
      bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: is_d ? 32'h3000 : 32'h400, wdata: 32'h0, len: 1});
      if (is_d) d_exp.push_back('{err: 1'b0, rdata: 32'h0000_55AA});
      else      i_exp.push_back('{err: 1'b0, rdata: 32'h0000_55AA});
    end
    i_req = 1'b1; d_req = 1'b1;
    rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 200 && acks < 10; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (acks != 10 || bus_exp.size() != 0) begin
      errors++;
      $display("FAIL contention: got %0d acks with %0d grants pending, need 10 acks and 0 pending", acks, bus_exp.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    rsp_wait = -1;
    bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h4000, wdata: 32'h0, len: 5});
    d_exp.push_back('{err: 1'b1, rdata: 32'h0});
    d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h4000; d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 30);
    d_req = 1'b0;
    checks++;
    if (!d_ack) begin errors++; $display("FAIL timeout_ack: got no d_ack in %0d cycles, need ack", n); end
    repeat (2) @(negedge clk);
    rsp_wait = 0; rsp_rdata = 32'h0000_0077;
    bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h104, wdata: 32'h0, len: 1});
    i_exp.push_back('{err: 1'b0, rdata: 32'h0000_0077});
    i_addr = 32'h104; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 20);
    i_req = 1'b0;
    checks++;
    if (!i_ack) begin errors++; $display("FAIL fetch_after_timeout: got no i_ack, need ack"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int n;
    rsp_wait = -1;
    bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h5000, wdata: 32'h0, len: 0});
    d_exp.push_back('{err: 1'b0, rdata: 32'h0});
    d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h5000; i_addr = 32'h600;
    d_req = 1'b1; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_cyc && n < 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_cyc !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_drop: got m_cyc=%b d_ack=%b, need 0 0", m_cyc, d_ack);
    end
    checks++;
    if (dut.starve_cnt_q !== '0) begin
      errors++;
      $display("FAIL reset_starve: got starve_cnt=%0d, need 0", dut.starve_cnt_q);
    end
    d_req = 1'b0;
    d_exp.delete();
    rsp_wait = 0; rsp_rdata = 32'h0000_0099;
    bus_exp.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h600, wdata: 32'h0, len: 1});
    i_exp.push_back('{err: 1'b0, rdata: 32'h0000_0099});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_cyc !== 1'b1 || m_addr !== 32'h600) begin
      errors++;
      $display("FAIL reset_first_grant: got m_cyc=%b m_addr=%h, need 1 00000600", m_cyc, m_addr);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 20);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_exp.size() != 0 || i_exp.size() != 0 || d_exp.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d/%0d/%0d pending, need 0/0/0", bus_exp.size(), i_exp.size(), d_exp.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_access(1'b1, 4'h3, 32'h2000, 32'h0000_BEEF, 3, 32'h1234_5678);
    test_data_access(1'b0, 4'hF, 32'h2004, 32'h0, 1, 32'hCAFE_F00D);
    test_contention();
    test_timeout();
    test_data_access(1'b0, 4'hF, 32'h2008, 32'h0, 4, 32'hA5A5_0001);
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, need completion");
    $fatal(1);
  end

endmodule
